// File: rtl/arb_req_client.sv
// Requester-side agent for a two-port grant arbiter: turns a start/len command
// into a req/gnt exchange, one beat per granted cycle, then a mandatory req-low gap.
module arb_req_client #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             beat,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, XFER, GAP_ST} state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0]       GAP_LOAD  = 4'(GAP);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic [7:0]       wait_cnt;
  logic [3:0]       gap_cnt;

  // req, busy, done and timeout are registered alongside the state so they
  // change only on clock edges (or immediately on reset).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      remain   <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      req      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            remain   <= len;
            wait_cnt <= '0;
            req      <= 1'b1;
            busy     <= 1'b1;
            state    <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (gnt) begin
            state <= XFER;
          end else if (wait_cnt == WAIT_LAST) begin
            req     <= 1'b0;
            timeout <= 1'b1;
            gap_cnt <= GAP_LOAD;
            state   <= GAP_ST;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        XFER: begin
          // A cycle without gnt is a pre-emption: hold req and keep the count.
          if (gnt) begin
            remain <= remain - ONE;
            if (remain == ONE) begin
              req     <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= GAP_LOAD;
              state   <= GAP_ST;
            end
          end
        end
        GAP_ST: begin
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign beat = (state == XFER) && gnt;

endmodule

// File: tb/tb_arb_req_client.sv
// Scoreboard bench for arb_req_client: stimulus queues expected beat/done/timeout
// events, a negedge monitor pops them as the DUTs raise those outputs.
module tb_arb_req_client;

  localparam int EV_BEAT = 0;
  localparam int EV_DONE = 1;
  localparam int EV_TOUT = 2;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic       tb_gnt = 1'b0;
  logic       arb_mode = 1'b0;
  logic       gnt0, gnt1;
  logic       req0, req1, beat0, beat1, busy0, busy1;
  logic       done0, done1, timeout0, timeout1;

  logic [1:0] owner;
  logic       last_one;

  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;
  int  both_beat = 0;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  arb_req_client dut0 (
    .clock(clock), .reset(reset), .start(start0), .len(len0), .gnt(gnt0),
    .req(req0), .beat(beat0), .busy(busy0), .done(done0), .timeout(timeout0)
  );

  arb_req_client dut1 (
    .clock(clock), .reset(reset), .start(start1), .len(len1), .gnt(gnt1),
    .req(req1), .beat(beat1), .busy(busy1), .done(done1), .timeout(timeout1)
  );

  // Reference arbiter: the owner keeps the grant while it requests; on a
  // contended hand-over the client not served last wins.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      owner    <= 2'd0;
      last_one <= 1'b1;
    end else if (!((owner == 2'd1) && req0) && !((owner == 2'd2) && req1)) begin
      if (req0 && req1) begin
        owner    <= last_one ? 2'd1 : 2'd2;
        last_one <= ~last_one;
      end else if (req0) begin
        owner    <= 2'd1;
        last_one <= 1'b0;
      end else if (req1) begin
        owner    <= 2'd2;
        last_one <= 1'b1;
      end else begin
        owner <= 2'd0;
      end
    end
  end

  assign gnt0 = arb_mode ? ((owner == 2'd1) && req0) : tb_gnt;
  assign gnt1 = arb_mode && (owner == 2'd2) && req1;

  function automatic string kname(input int kind);
    case (kind)
      EV_BEAT: return "beat";
      EV_DONE: return "done";
      default: return "timeout";
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
  endtask

  task automatic expect_evt(input int which, input int c, input int kind);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic observe(input int which, input int kind);
    ev_t e;
    int  n;
    n = (which == 0) ? q0.size() : q1.size();
    checks++;
    if (n == 0) begin
      $display("[TB] FAIL dut%0d unexpected %s at cycle %0d: got event, required none",
               which, kname(kind), cyc);
    end else begin
      e = (which == 0) ? q0.pop_front() : q1.pop_front();
      if (e.cyc == cyc && e.kind == kind) passes++;
      else $display("[TB] FAIL dut%0d event: got %s at cycle %0d, required %s at cycle %0d",
                    which, kname(kind), cyc, kname(e.kind), e.cyc);
    end
  endtask

  task automatic check_drained(input string name);
    check_int({name, " dut0 pending events"}, q0.size(), 0);
    check_int({name, " dut1 pending events"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  always @(negedge clock) begin
    if (beat0)    observe(0, EV_BEAT);
    if (done0)    observe(0, EV_DONE);
    if (timeout0) observe(0, EV_TOUT);
    if (beat1)    observe(1, EV_BEAT);
    if (done1)    observe(1, EV_DONE);
    if (timeout1) observe(1, EV_TOUT);
    if (beat0 && beat1) both_beat++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int nb;
    int req_cnt;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_bit("reset req", req0, 1'b0);
    check_bit("reset busy", busy0, 1'b0);
    check_bit("reset done", done0, 1'b0);
    check_bit("reset timeout", timeout0, 1'b0);
    check_bit("reset beat", beat0, 1'b0);
    step();
    reset = 1'b0;

    // Basic: len=3, gnt tied high
    $display("[TB] basic transfer");
    step();
    t0 = cyc;
    expect_evt(0, t0 + 2, EV_BEAT);
    expect_evt(0, t0 + 3, EV_BEAT);
    expect_evt(0, t0 + 4, EV_BEAT);
    expect_evt(0, t0 + 5, EV_DONE);
    for (int k = 0; k <= 7; k++) begin
      start0 = (k == 0);
      len0   = 4'd3;
      tb_gnt = 1'b1;
      @(negedge clock);
      if (k == 0) check_bit("basic req before start", req0, 1'b0);
      if (k == 1 || k == 4) check_bit("basic req high", req0, 1'b1);
      if (k == 1) check_bit("basic busy after start", busy0, 1'b1);
      if (k == 5) check_bit("basic req low at done", req0, 1'b0);
      if (k == 5) check_bit("basic busy in gap", busy0, 1'b1);
      if (k == 6) check_bit("basic busy cleared", busy0, 1'b0);
      step();
    end
    check_drained("basic");

    // Pre-emption: gnt drops for two cycles after the 2nd beat
    $display("[TB] pre-emption");
    t0 = cyc;
    nb = 0;
    expect_evt(0, t0 + 2, EV_BEAT);
    expect_evt(0, t0 + 3, EV_BEAT);
    expect_evt(0, t0 + 6, EV_BEAT);
    expect_evt(0, t0 + 7, EV_BEAT);
    expect_evt(0, t0 + 8, EV_DONE);
    for (int k = 0; k <= 10; k++) begin
      start0 = (k == 0);
      len0   = 4'd4;
      tb_gnt = !(k == 4 || k == 5);
      @(negedge clock);
      if (beat0) nb++;
      if (k == 4 || k == 5) check_bit("preempt req held", req0, 1'b1);
      if (k == 10) check_bit("preempt busy cleared", busy0, 1'b0);
      step();
    end
    check_int("preempt beat count", nb, 4);
    check_drained("preempt");

    // Timeout: gnt never arrives
    $display("[TB] timeout");
    t0 = cyc;
    req_cnt = 0;
    expect_evt(0, t0 + 16, EV_TOUT);
    for (int k = 0; k <= 18; k++) begin
      start0 = (k == 0);
      len0   = 4'd2;
      tb_gnt = 1'b0;
      @(negedge clock);
      if (req0) req_cnt++;
      if (k == 15) check_bit("timeout req last cycle", req0, 1'b1);
      if (k == 16) check_bit("timeout req dropped", req0, 1'b0);
      if (k == 16) check_bit("timeout busy in gap", busy0, 1'b1);
      if (k == 18) check_bit("timeout back to idle", busy0, 1'b0);
      step();
    end
    check_int("timeout req cycles", req_cnt, 15);
    check_drained("timeout");

    // Ignored commands: len=0 in IDLE, start during XFER
    $display("[TB] ignored commands");
    t0 = cyc;
    nb = 0;
    expect_evt(0, t0 + 4, EV_BEAT);
    expect_evt(0, t0 + 5, EV_BEAT);
    expect_evt(0, t0 + 6, EV_DONE);
    for (int k = 0; k <= 12; k++) begin
      start0 = (k == 0 || k == 2 || k == 4);
      len0   = (k == 0) ? 4'd0 : ((k == 4) ? 4'd5 : 4'd2);
      tb_gnt = 1'b1;
      @(negedge clock);
      if (beat0) nb++;
      if (k == 1) check_bit("len0 ignored busy", busy0, 1'b0);
      if (k == 1) check_bit("len0 ignored req", req0, 1'b0);
      if (k == 7) check_bit("ignored busy cleared", busy0, 1'b0);
      if (k == 12) check_bit("start in xfer not queued", busy0, 1'b0);
      step();
    end
    start0 = 1'b0;
    check_int("ignored beat count", nb, 2);
    check_drained("ignored");

    // Reset after the first of three beats, then a fresh transfer
    $display("[TB] reset mid-transfer");
    t0 = cyc;
    expect_evt(0, t0 + 2, EV_BEAT);
    expect_evt(0, t0 + 8, EV_BEAT);
    expect_evt(0, t0 + 9, EV_BEAT);
    expect_evt(0, t0 + 10, EV_DONE);
    for (int k = 0; k <= 13; k++) begin
      start0 = (k == 0 || k == 6);
      len0   = (k == 0) ? 4'd3 : 4'd2;
      tb_gnt = 1'b1;
      reset  = (k == 3 || k == 4);
      @(negedge clock);
      if (k == 3) begin
        check_bit("mid reset req", req0, 1'b0);
        check_bit("mid reset busy", busy0, 1'b0);
        check_bit("mid reset beat", beat0, 1'b0);
        check_bit("mid reset done", done0, 1'b0);
        check_bit("mid reset timeout", timeout0, 1'b0);
      end
      if (k == 10) check_bit("post reset req low at done", req0, 1'b0);
      if (k == 10) check_bit("post reset busy in gap", busy0, 1'b1);
      if (k == 11) check_bit("post reset idle", busy0, 1'b0);
      step();
    end
    check_drained("reset");

    // Two clients sharing the reference arbiter
    $display("[TB] two clients");
    tb_gnt   = 1'b0;
    arb_mode = 1'b1;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    step();
    t0 = cyc;
    both_beat = 0;
    expect_evt(0, t0 + 3, EV_BEAT);
    expect_evt(0, t0 + 4, EV_BEAT);
    expect_evt(0, t0 + 5, EV_DONE);
    expect_evt(1, t0 + 7, EV_BEAT);
    expect_evt(1, t0 + 8, EV_BEAT);
    expect_evt(1, t0 + 9, EV_DONE);
    for (int k = 0; k <= 12; k++) begin
      start0 = (k == 0);
      start1 = (k == 0);
      len0   = 4'd2;
      len1   = 4'd2;
      @(negedge clock);
      if (k == 5) check_bit("client0 released req", req0, 1'b0);
      if (k == 5) check_bit("client1 still waiting", req1, 1'b1);
      if (k == 12) check_bit("client1 idle", busy1, 1'b0);
      step();
    end
    check_int("overlapping beats", both_beat, 0);
    check_drained("two clients");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
